// File: rtl/ehgu_fifo_arb.sv
// ehgu_fifo_arb: round-robin burst arbiter letting NREQ requesters share one FIFO write port.
// Define EHGU_FIFO_ARB_CNT_EN to enable the saturating accepted-beat counter on beat_cnt.
module ehgu_fifo_arb #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 128,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk0,
    input  logic                       wrstn,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            ack,
    input  logic                       fifo_pop,
    output logic                       fifo_en,
    output logic                       fifo_din_valid,
    output logic [WIDTH-1:0]           fifo_din,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       full,
    output logic                       empty,
    output logic                       underflow_err,
    output logic [15:0]                beat_cnt
);
    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, BURST, FULL_WAIT} state_t;
    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, last_q, last_d, pick, cand;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          udf_q, udf_d, found, own_req, accept, pop_ok;

    assign own_req        = req[owner_q];
    assign full           = occ_q == CW'(DEPTH);
    assign empty          = occ_q == '0;
    assign accept         = state_q == BURST && own_req && !full;
    assign pop_ok         = fifo_pop && !empty;
    assign occupancy      = occ_q;
    assign underflow_err  = udf_q;
    assign fifo_din_valid = accept;
    assign fifo_din       = accept ? req_data[owner_q*WIDTH +: WIDTH] : '0;
    assign fifo_en        = state_q != IDLE || !empty;
    assign udf_d          = udf_q | (fifo_pop & empty);
    assign occ_d          = (accept && !pop_ok) ? occ_q + 1'b1 :
                            (pop_ok && !accept) ? occ_q - 1'b1 : occ_q;

    always_comb begin
        ack          = '0;
        ack[owner_q] = accept;
    end

    // first requester after the previous owner wins
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = OW'((int'(last_q) + k) % NREQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (found && !full) begin
                    state_d = BURST;
                    owner_d = pick;
                    bcnt_d  = '0;
                end
            end
            BURST: begin
                if (!own_req) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (full) begin
                    state_d = FULL_WAIT;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            FULL_WAIT: begin
                if (!own_req) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (!full) begin
                    state_d = BURST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk0 or negedge wrstn) begin
        if (!wrstn) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            bcnt_q  <= '0;
            occ_q   <= '0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            occ_q   <= occ_d;
            udf_q   <= udf_d;
        end
    end

`ifdef EHGU_FIFO_ARB_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d    = (accept && cnt_q != 16'hFFFF) ? cnt_q + 1'b1 : cnt_q;
    assign beat_cnt = cnt_q;
    always_ff @(posedge clk0 or negedge wrstn) begin
        if (!wrstn) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign beat_cnt = '0;
`endif
endmodule

// File: tb/tb_ehgu_fifo_arb.sv
// tb_ehgu_fifo_arb: randomized bench for ehgu_fifo_arb against a queue-based arbitration model.
module tb_ehgu_fifo_arb;
    localparam int NREQ = 4, WIDTH = 8, DEPTH = 128, MAX_BURST = 4;
    localparam logic [40:0] RST_VEC = {4'b0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
    logic                  clk0 = 1'b0, wrstn = 1'b0, fifo_pop = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       ack;
    logic                  fifo_en, fifo_din_valid, full, empty, underflow_err;
    logic [WIDTH-1:0]      fifo_din;
    logic [7:0]            occupancy;
    logic [15:0]           beat_cnt;
    logic [40:0]           obs, exp_vec;
    int                    checks = 0, errors = 0;
    logic [WIDTH-1:0]      mq[$];
    bit                    m_busy, m_stall, m_udf, m_acc;
    int                    m_owner, m_last, m_beats, m_cnt;

    ehgu_fifo_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk0(clk0), .wrstn(wrstn), .req(req), .req_data(req_data), .ack(ack),
        .fifo_pop(fifo_pop), .fifo_en(fifo_en), .fifo_din_valid(fifo_din_valid),
        .fifo_din(fifo_din), .occupancy(occupancy), .full(full), .empty(empty),
        .underflow_err(underflow_err), .beat_cnt(beat_cnt)
    );

    assign obs = {ack, fifo_din_valid, fifo_din, occupancy, full, empty, underflow_err, fifo_en, beat_cnt};

    initial forever #5 clk0 = ~clk0;

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_stall = 0; m_udf = 0; m_acc = 0;
        m_owner = 0; m_last = NREQ - 1; m_beats = 0; m_cnt = 0;
    endtask

    task automatic eval();
        int n = mq.size();
        logic [NREQ-1:0] a;
        logic [WIDTH-1:0] d;
        logic [15:0] c;
        m_acc = m_busy && !m_stall && req[m_owner] && n < DEPTH;
        a = m_acc ? NREQ'(1 << m_owner) : '0;
        d = m_acc ? req_data[m_owner*WIDTH +: WIDTH] : '0;
`ifdef EHGU_FIFO_ARB_CNT_EN
        c = 16'(m_cnt);
`else
        c = 16'd0;
`endif
        exp_vec = {a, m_acc, d, 8'(n), n == DEPTH, n == 0, m_udf, m_busy || n != 0, c};
    endtask

    task automatic advance();
        int n = mq.size();
        if (fifo_pop && n == 0) m_udf = 1;
        if (fifo_pop && n > 0) void'(mq.pop_front());
        if (m_acc) begin
            mq.push_back(req_data[m_owner*WIDTH +: WIDTH]);
            if (m_cnt < 65535) m_cnt++;
        end
        if (!m_busy) begin
            if (req != 0 && n < DEPTH) begin
                for (int k = 1; k <= NREQ; k++)
                    if (req[(m_last + k) % NREQ]) begin
                        m_owner = (m_last + k) % NREQ;
                        break;
                    end
                m_busy = 1; m_stall = 0; m_beats = 0;
            end
        end else if (!req[m_owner]) begin
            m_busy = 0; m_last = m_owner;
        end else if (m_stall) begin
            if (n < DEPTH) m_stall = 0;
        end else if (n == DEPTH) begin
            m_stall = 1;
        end else begin
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_busy = 0; m_last = m_owner;
            end
        end
    endtask

    task automatic apply(input logic [NREQ-1:0] r, input logic [31:0] d, input logic p);
        @(negedge clk0);
        req = r; req_data = d; fifo_pop = p;
        #1 eval();
    endtask

    task automatic do_reset();
        @(negedge clk0);
        wrstn = 0; req = '0; fifo_pop = 0;
        model_reset();
        repeat (2) @(negedge clk0);
        wrstn = 1;
    endtask

    task automatic test_reset();
        @(negedge clk0);
        wrstn = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            req = NREQ'($urandom); req_data = $urandom; fifo_pop = 1'($urandom);
            #1 checks++;
            if (obs !== RST_VEC) begin errors++; $display("FAIL reset %0d: got %h want %h", i, obs, RST_VEC); end
            @(negedge clk0);
        end
        req = '0; fifo_pop = 0; wrstn = 1;
    endtask

    task automatic test_single();
        bit [0:9] pat = 10'b0111101111;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            apply(4'b0001, $urandom, 0);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL single cyc%0d: got %h want %h", c, obs, exp_vec); end
            checks++;
            if (ack[0] !== pat[c]) begin errors++; $display("FAIL single_ack cyc%0d: got %b want %b", c, ack[0], pat[c]); end
            advance();
        end
        @(negedge clk0);
        req = '0;
        #1 checks++;
        if (occupancy !== 8'd8) begin errors++; $display("FAIL single_occ: got %0d want 8", occupancy); end
    endtask

    task automatic test_round_robin();
        int b = 0;
        do_reset();
        for (int c = 0; c < 25; c++) begin
            apply(4'b1111, $urandom, 0);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL rr cyc%0d: got %h want %h", c, obs, exp_vec); end
            if (ack != 0) begin
                checks++;
                if (ack !== NREQ'(1 << ((b / 4) % 4)) || fifo_din !== req_data[((b / 4) % 4)*WIDTH +: WIDTH]) begin
                    errors++; $display("FAIL rr_owner beat%0d: got ack %b din %h", b, ack, fifo_din);
                end
                b++;
            end
            advance();
        end
        checks++;
        if (b != 20) begin errors++; $display("FAIL rr_beats: got %0d want 20", b); end
    endtask

    task automatic test_full();
        int acks = 0;
        do_reset();
        for (int c = 0; c < 175; c++) begin
            apply(4'b0001, $urandom, c == 3);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL full cyc%0d: got %h want %h", c, obs, exp_vec); end
            advance();
        end
        apply(4'b0001, $urandom, 0);
        checks++;
        if (full !== 1'b1 || ack !== 4'b0 || fifo_en !== 1'b1 || occupancy !== 8'd128) begin
            errors++; $display("FAIL full_hold: got full %b ack %b en %b occ %0d", full, ack, fifo_en, occupancy);
        end
        advance();
        for (int c = 0; c < 6; c++) begin
            apply(4'b0001, $urandom, c == 0);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL full_pop cyc%0d: got %h want %h", c, obs, exp_vec); end
            if (ack != 0) acks++;
            advance();
        end
        @(negedge clk0);
        req = '0;
        #1 checks++;
        if (acks != 1 || occupancy !== 8'd128) begin errors++; $display("FAIL full_refill: got %0d beats occ %0d want 1 beat occ 128", acks, occupancy); end
    endtask

    task automatic test_pop_accept();
        bit popped = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            apply(4'b0001, $urandom, 0);
            if (popped) begin
                checks++;
                if (occupancy !== 8'd5) begin errors++; $display("FAIL pop_accept: got occ %0d want 5", occupancy); end
                popped = 0;
                c = 20;
            end else if (m_acc && mq.size() == 5) begin
                fifo_pop = 1; popped = 1;
            end
            #1 checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL pop_accept cyc%0d: got %h want %h", c, obs, exp_vec); end
            advance();
        end
        for (int c = 0; c < 14; c++) begin
            apply('0, $urandom, c < 12);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL underflow cyc%0d: got %h want %h", c, obs, exp_vec); end
            advance();
        end
        checks++;
        if (underflow_err !== 1'b1 || occupancy !== 8'd0) begin errors++; $display("FAIL underflow_flag: got udf %b occ %0d want 1 0", underflow_err, occupancy); end
    endtask

    task automatic test_drop();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            apply(c < 3 ? 4'b0100 : 4'b1001, $urandom, 0);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL drop cyc%0d: got %h want %h", c, obs, exp_vec); end
            checks++;
            if (ack !== (c == 1 || c == 2 ? 4'b0100 : c >= 5 ? 4'b1000 : 4'b0000)) begin
                errors++; $display("FAIL drop_ack cyc%0d: got %b", c, ack);
            end
            advance();
        end
        @(negedge clk0);
        wrstn = 0;
        #1 checks++;
        if (obs !== RST_VEC) begin errors++; $display("FAIL midburst_reset: got %h want %h", obs, RST_VEC); end
        model_reset();
        req = '0;
        #1 wrstn = 1;
        #1 eval();
        advance();
        for (int c = 0; c < 2; c++) begin
            apply('0, $urandom, 0);
            checks++;
            if (obs !== exp_vec || ack !== 4'b0) begin errors++; $display("FAIL post_reset cyc%0d: got %h want %h", c, obs, exp_vec); end
            advance();
        end
    endtask

    task automatic test_count();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            apply(4'b0001, $urandom, 0);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL count cyc%0d: got %h want %h", c, obs, exp_vec); end
            advance();
        end
        @(negedge clk0);
        req = '0;
        #1 checks++;
`ifdef EHGU_FIFO_ARB_CNT_EN
        if (beat_cnt !== 16'd10) begin errors++; $display("FAIL beat_cnt: got %0d want 10", beat_cnt); end
`else
        if (beat_cnt !== 16'd0) begin errors++; $display("FAIL beat_cnt: got %0d want 0", beat_cnt); end
`endif
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r = '0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) r = NREQ'($urandom);
            apply(r, $urandom, $urandom_range(0, c < 1500 ? 1 : 3) == 0);
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL random cyc%0d: got %h want %h", c, obs, exp_vec); end
            advance();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_pop_accept();
        test_drop();
        test_count();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
